// File: rtl/crypto_sm4_round_seq_if.sv
// Request/response bundle for the SM4 full-round sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface crypto_sm4_round_seq_if;
    localparam int unsigned WORD_W = 32;

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic              op_i;
    logic [WORD_W-1:0] x0_i;
    logic [WORD_W-1:0] x1_i;
    logic [WORD_W-1:0] x2_i;
    logic [WORD_W-1:0] x3_i;
    logic [WORD_W-1:0] rk_i;
    logic              valid_o;
    logic              ready_i;
    logic [WORD_W-1:0] result_o;
    logic              busy_o;

    modport master (
        output flush_i, valid_i, op_i, x0_i, x1_i, x2_i, x3_i, rk_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, x0_i, x1_i, x2_i, x3_i, rk_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/crypto_sm4_round_seq.sv
// SM4 round / key-expansion sequencer: four chained byte-select steps
// (SM4ED or SM4KS style) over one shared datapath, with valid/ready handshakes.
module crypto_sm4_round_seq (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    crypto_sm4_round_seq_if.slave        bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BS_W   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // One byte-select step: rs1 ^ rol(L(S(rs2.byte[bs])), 8*bs), L or L' chosen by op.
    function automatic logic [WORD_W-1:0] sm4_step(input logic              op,
                                                   input logic [BS_W-1:0]   bs,
                                                   input logic [WORD_W-1:0] rs1,
                                                   input logic [WORD_W-1:0] rs2);
        logic [7:0]        sel;
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] l;
        logic [WORD_W-1:0] z;
        case (bs)
            2'd0:    sel = rs2[7:0];
            2'd1:    sel = rs2[15:8];
            2'd2:    sel = rs2[23:16];
            default: sel = rs2[31:24];
        endcase
        x = {24'h0, SBOX[sel]};
        // x occupies the low byte, so every rotate amount up to 24 is a plain shift.
        if (op) l = x ^ (x << 13) ^ (x << 23);
        else    l = x ^ (x << 2) ^ (x << 10) ^ (x << 18) ^ (x << 24);
        case (bs)
            2'd0:    z = l;
            2'd1:    z = {l[23:0], l[31:24]};
            2'd2:    z = {l[15:0], l[31:16]};
            default: z = {l[7:0],  l[31:8]};
        endcase
        return rs1 ^ z;
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [BS_W-1:0]   bs_q,     bs_d;
    logic [WORD_W-1:0] acc_q,    acc_d;
    logic [WORD_W-1:0] t_q,      t_d;
    logic              op_q,     op_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              ready_q,  ready_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic [WORD_W-1:0] step_res;

    always_comb begin
        state_d  = state_q;
        bs_d     = bs_q;
        acc_d    = acc_q;
        t_d      = t_q;
        op_d     = op_q;
        result_d = result_q;
        step_res = sm4_step(op_q, bs_q, acc_q, t_q);

        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        t_d     = bus.x1_i ^ bus.x2_i ^ bus.x3_i ^ bus.rk_i;
                        acc_d   = bus.x0_i;
                        op_d    = bus.op_i;
                        bs_d    = '0;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_d = step_res;
                    bs_d  = bs_q + BS_W'(1);
                    if (bs_q == BS_W'(3)) begin
                        state_d  = ST_DONE;
                        result_d = step_res;
                    end
                end
                ST_DONE: begin
                    if (bus.ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Status flags are a pure function of the next state, so they register cleanly.
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d == ST_CALC) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            bs_q     <= '0;
            acc_q    <= '0;
            t_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bs_q     <= bs_d;
            acc_q    <= acc_d;
            t_q      <= t_d;
            op_q     <= op_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = busy_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_crypto_sm4_round_seq.sv
// Directed plus randomized bench for crypto_sm4_round_seq against a whole-word SM4 T/T' model.
module tb_crypto_sm4_round_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    crypto_sm4_round_seq_if bus ();

    crypto_sm4_round_seq dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] SBOX_REF [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    // Golden: X4 = X0 ^ L(S(X1^X2^X3^rk)) for a round, K4 = K0 ^ L'(S(...)) for a key step.
    function automatic logic [31:0] golden(input logic op, input logic [31:0] a0, a1, a2, a3, k);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] l;
        w = a1 ^ a2 ^ a3 ^ k;
        for (int i = 0; i < 4; i++) b[8*i +: 8] = SBOX_REF[w[8*i +: 8]];
        if (op) l = b ^ rol(b, 13) ^ rol(b, 23);
        else    l = b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
        return a0 ^ l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic op, input logic [31:0] a0, a1, a2, a3, k);
        bus.op_i    = op;
        bus.x0_i    = a0;
        bus.x1_i    = a1;
        bus.x2_i    = a2;
        bus.x3_i    = a3;
        bus.rk_i    = k;
        bus.valid_i = 1'b1;
    endtask

    // Issue one request from IDLE, scramble the operands after accept, wait for valid_o.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a0, a1, a2, a3, k,
                          output logic [31:0] res);
        int cnt;
        drive_req(op, a0, a1, a2, a3, k);
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        step();
        bus.valid_i = 1'b0;
        drive_req(~op, $urandom, $urandom, $urandom, $urandom, $urandom);
        bus.valid_i = 1'b0;
        cnt = 0;
        while (bus.valid_o !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd4);
        res = bus.result_o;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [31:0] w [5];
        logic        op;
        int          dly;
        bit          held;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drive_req(1'b0, '0, '0, '0, '0, '0);
        bus.valid_i = 1'b0;
        #12;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_result", bus.result_o, 32'h0);
        rst_n = 1'b1;
        step();

        // Round on all-zero words
        run_op("t1", 1'b0, '0, '0, '0, '0, '0, res);
        check("t1_result", res, 32'h5B5B5B5B);
        check("t1_busy_done", 32'(bus.busy_o), 32'd1);
        step();
        check("t1_ready_after", 32'(bus.ready_o), 32'd1);
        check("t1_valid_after", 32'(bus.valid_o), 32'd0);

        // Key step, zero and all-ones K0
        run_op("t2a", 1'b1, '0, '0, '0, '0, '0, res);
        check("t2a_result", res, 32'h67676767);
        step();
        run_op("t2b", 1'b1, 32'hFFFFFFFF, '0, '0, '0, '0, res);
        check("t2b_result", res, 32'h98989898);
        step();

        // Backpressure: 10 stalled cycles in DONE with a competing request
        bus.ready_i = 1'b0;
        run_op("t3", 1'b0, '0, '0, '0, '0, '0, res);
        drive_req(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        held = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.valid_o !== 1'b1 || bus.result_o !== 32'h5B5B5B5B || bus.ready_o !== 1'b0) held = 1'b0;
            step();
        end
        check("t3_held", 32'(held), 32'd1);
        check("t3_result_hold", bus.result_o, 32'h5B5B5B5B);
        check("t3_ready_low", 32'(bus.ready_o), 32'd0);
        bus.ready_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        check("t3_ready_idle", 32'(bus.ready_o), 32'd1);
        check("t3_valid_idle", 32'(bus.valid_o), 32'd0);
        step();
        check("t3_no_accept", 32'(bus.busy_o), 32'd0);
        check("t3_result_keep", bus.result_o, 32'h5B5B5B5B);

        // Flush in the second CALC cycle, then a clean request
        drive_req(1'b1, 32'hFFFFFFFF, '0, '0, '0, '0);
        step();
        bus.valid_i = 1'b0;
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("t4_ready", 32'(bus.ready_o), 32'd1);
        check("t4_busy",  32'(bus.busy_o),  32'd0);
        held = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bus.valid_o !== 1'b0) held = 1'b0;
            step();
        end
        check("t4_no_valid", 32'(held), 32'd1);
        check("t4_result_unchanged", bus.result_o, 32'h5B5B5B5B);
        run_op("t4r", 1'b0, '0, '0, '0, '0, '0, res);
        check("t4r_result", res, 32'h5B5B5B5B);
        step();

        // Flush beats valid in IDLE
        drive_req(1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        bus.flush_i = 1'b1;
        step();
        check("t6_busy",  32'(bus.busy_o),  32'd0);
        check("t6_ready", 32'(bus.ready_o), 32'd1);
        step();
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("t6_busy2", 32'(bus.busy_o), 32'd0);
        step();
        check("t6_idle", 32'(bus.busy_o), 32'd0);

        // Async reset in the third CALC cycle
        drive_req(1'b1, 32'hFFFFFFFF, '0, '0, '0, '0);
        step();
        bus.valid_i = 1'b0;
        step();
        step();
        check("t5_busy_pre", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_ready",  32'(bus.ready_o), 32'd1);
        check("t5_valid",  32'(bus.valid_o), 32'd0);
        check("t5_busy",   32'(bus.busy_o),  32'd0);
        check("t5_result", bus.result_o, 32'h0);
        #3;
        rst_n = 1'b1;
        step();
        check("t5_post_valid", 32'(bus.valid_o), 32'd0);

        // Randomized rounds and key steps with random consumer stalls
        for (int i = 0; i < 32; i++) begin
            op = 1'($urandom_range(0, 1));
            for (int j = 0; j < 5; j++) w[j] = $urandom;
            exp = golden(op, w[0], w[1], w[2], w[3], w[4]);
            bus.ready_i = 1'b0;
            run_op($sformatf("rnd%0d", i), op, w[0], w[1], w[2], w[3], w[4], res);
            check($sformatf("rnd%0d_result", i), res, exp);
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) step();
            check($sformatf("rnd%0d_stall", i), bus.result_o, exp);
            bus.ready_i = 1'b1;
            step();
            check($sformatf("rnd%0d_taken", i), 32'(bus.valid_o), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
